apuf_response_collector: RTL and testbench

// Drives repeated evaluations of one arbiter-PUF stage and turns the arbiter flop output into a voted, packed response word.
// Per response bit: present challenge, preset arbiter, launch, wait, sample arb_q. Repeat NVOTE times, majority-vote, shift in.

---
 rtl/apuf_pkg.sv | 25 ++
 rtl/apuf_sync2.sv | 25 ++
 rtl/apuf_response_collector.sv | 122 ++++++++++++
 tb/tb_apuf_response_collector.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apuf_pkg.sv
// apuf_pkg: shared definitions for the arbiter-PUF response collector.
//   state_t    : collector FSM states
//   LFSR_TAPS  : Galois mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shift form)
//   lfsr_next  : one Galois LFSR step, used to walk the challenge sequence
package apuf_pkg;

  localparam int          LFSR_W    = 64;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LAUNCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_DONE
  } state_t;

  // Shift right; the bit falling out of the LSB folds back through the taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] chal);
    return {1'b0, chal[LFSR_W-1:1]} ^ (chal[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/apuf_sync2.sv
// apuf_sync2: two-flop synchronizer for the asynchronous arbiter output.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module apuf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/apuf_response_collector.sv
// apuf_response_collector: repeatedly evaluates one arbiter-PUF stage, majority
// votes NVOTE evaluations per bit and packs RESP_W voted bits into a response.
//   clk, rst        : clock, asynchronous active-low reset
//   start, seed     : begin a collection from challenge seed (0 becomes 1)
//   busy            : high outside IDLE
//   challenge       : delay-chain select bits for the current response bit
//   launch          : one-cycle pulse into both chain inputs
//   arb_rst         : arbiter preset request
//   arb_q           : arbiter flop output, asynchronous to clk
//   resp_valid/ready: response handshake
//   resp_data       : voted response, bit k from the k-th challenge
//   resp_unstable   : bit k set when its votes were not unanimous
module apuf_response_collector
  import apuf_pkg::*;
#(
  parameter int CHAL_W = 64,
  parameter int RESP_W = 32,
  parameter int NVOTE  = 5,
  parameter int SETTLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic              busy,
  output logic [CHAL_W-1:0] challenge,
  output logic              launch,
  output logic              arb_rst,
  input  logic              arb_q,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [RESP_W-1:0] resp_unstable
);

  localparam int BIT_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int VOTE_W = (NVOTE  > 1) ? $clog2(NVOTE)  : 1;
  localparam int ONES_W = $clog2(NVOTE + 1);
  localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state;
  logic [BIT_W-1:0]  bit_idx;
  logic [VOTE_W-1:0] vote_idx;
  logic [ONES_W-1:0] ones;
  logic [SET_W-1:0]  set_cnt;
  logic              arb_s;

  apuf_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (arb_q),
    .q   (arb_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      bit_idx       <= '0;
      vote_idx      <= '0;
      ones          <= '0;
      set_cnt       <= '0;
      challenge     <= '0;
      resp_data     <= '0;
      resp_unstable <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          challenge     <= (seed == '0) ? CHAL_W'(1) : seed;
          bit_idx       <= '0;
          vote_idx      <= '0;
          ones          <= '0;
          resp_data     <= '0;
          resp_unstable <= '0;
          state         <= ST_CLEAR;
        end
        ST_CLEAR:  state <= ST_LAUNCH;
        ST_LAUNCH: begin
          set_cnt <= '0;
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (set_cnt == SET_W'(SETTLE - 1)) state <= ST_SAMPLE;
          else                               set_cnt <= set_cnt + 1'b1;
        end
        ST_SAMPLE: begin
          ones <= ones + ONES_W'(arb_s);
          if (vote_idx == VOTE_W'(NVOTE - 1)) begin
            state <= ST_DECIDE;
          end else begin
            vote_idx <= vote_idx + 1'b1;
            state    <= ST_CLEAR;
          end
        end
        ST_DECIDE: begin
          resp_data[bit_idx]     <= (ones > ONES_W'(NVOTE / 2));
          resp_unstable[bit_idx] <= (ones != '0) && (ones != ONES_W'(NVOTE));
          challenge              <= lfsr_next(challenge);
          ones                   <= '0;
          vote_idx               <= '0;
          if (bit_idx == BIT_W'(RESP_W - 1)) begin
            state <= ST_DONE;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            state   <= ST_CLEAR;
          end
        end
        ST_DONE: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Arbiter is held in preset whenever no evaluation is in flight.
  always_comb begin
    busy       = (state != ST_IDLE);
    launch     = (state == ST_LAUNCH);
    resp_valid = (state == ST_DONE);
    arb_rst    = (state == ST_IDLE) || (state == ST_CLEAR) ||
                 (state == ST_DECIDE) || (state == ST_DONE);
  end

endmodule

// File: tb/tb_apuf_response_collector.sv
module tb_apuf_response_collector;
  import apuf_pkg::*;

  localparam int RW    = 4;
  localparam int NV    = 3;
  localparam int ST    = 2;
  localparam int NEVAL = RW * NV;
  localparam int LAT   = RW * (NV * (ST + 3) + 1);

  logic          clk = 1'b0;
  logic          rst, start, arb_q, resp_ready;
  logic [63:0]   seed;
  logic          busy, launch, arb_rst, resp_valid;
  logic [63:0]   challenge;
  logic [RW-1:0] resp_data, resp_unstable;

  apuf_response_collector #(.CHAL_W(64), .RESP_W(RW), .NVOTE(NV), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy),
    .challenge(challenge), .launch(launch), .arb_rst(arb_rst), .arb_q(arb_q),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_unstable(resp_unstable)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // observations gathered by the collection driver
  int            lat, nlaunch, low_in_win, pre_hi;
  logic [63:0]   chal_l [NEVAL];
  logic [63:0]   chal_s [NEVAL];
  logic [RW-1:0] data_after_start;

  // saved from the first all-ones collection for the restart comparison
  logic [RW-1:0] ref_data, ref_unst;
  logic [63:0]   ref_chal;

  // reference: majority and unanimity per bit from the vote list
  function automatic void model(input logic [NEVAL-1:0] v, output logic [RW-1:0] d,
                                output logic [RW-1:0] u);
    d = '0; u = '0;
    for (int b = 0; b < RW; b++) begin
      int n = 0;
      for (int k = 0; k < NV; k++) n += int'(v[b*NV+k]);
      d[b] = (2 * n > NV);
      u[b] = (n != 0) && (n != NV);
    end
  endfunction

  function automatic logic [63:0] chal_exp(input logic [63:0] sd, input int k);
    logic [63:0] c = (sd == 64'd0) ? 64'd1 : sd;
    for (int i = 0; i < k; i++) c = lfsr_next(c);
    return c;
  endfunction

  task automatic reset_dut();
    rst = 1'b0; start = 1'b0; resp_ready = 1'b0; arb_q = 1'b0; seed = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic accept();
    @(negedge clk); resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
  endtask

  // Runs one collection; arb_q for evaluation e is votes[e], applied at its launch.
  task automatic collect(input logic [63:0] sd, input logic [NEVAL-1:0] votes,
                         input bit pulse_busy);
    int   win_lo = -100, win_hi = -100, e = -1;
    logic prev_arb;
    nlaunch = 0; low_in_win = 0; pre_hi = 0; lat = -1;
    @(negedge clk); seed = sd; start = 1'b1;
    @(negedge clk); start = 1'b0;
    data_after_start = resp_data;
    prev_arb = arb_rst;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (pulse_busy && cyc == 10) begin start = 1'b1; seed = 64'hDEAD_BEEF_0000_1234; end
      if (pulse_busy && cyc == 11) start = 1'b0;
      if (launch === 1'b1) begin
        if (prev_arb === 1'b1) pre_hi++;
        e = nlaunch;
        if (e < NEVAL) begin chal_l[e] = challenge; arb_q = votes[e]; end
        nlaunch++;
        win_lo = cyc; win_hi = cyc + ST + 1;
      end
      if (cyc >= win_lo && cyc <= win_hi && arb_rst === 1'b0) low_in_win++;
      if (cyc == win_hi && e >= 0 && e < NEVAL) chal_s[e] = challenge;
      prev_arb = arb_rst;
      if (resp_valid === 1'b1) begin lat = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; resp_ready = 1'b0; arb_q = 1'b0; seed = '0;
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({busy, arb_rst, launch, resp_valid} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0100", {busy, arb_rst, launch, resp_valid});
    end
    vectors++;
    if ({resp_data, resp_unstable, challenge} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h/%h expected 0", resp_data, resp_unstable, challenge);
    end
    @(negedge clk); rst = 1'b1; @(negedge clk);
  endtask

  task automatic test_all_ones();
    collect(64'h5, '1, 1'b0);
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL ones_latency: got %0d expected %0d", lat, LAT); end
    vectors++;
    if (nlaunch !== NEVAL) begin miscompares++; $display("FAIL ones_launches: got %0d expected %0d", nlaunch, NEVAL); end
    vectors++;
    if ({resp_data, resp_unstable} !== {4'hF, 4'h0}) begin
      miscompares++; $display("FAIL ones_result: got %h/%h expected f/0", resp_data, resp_unstable);
    end
    for (int e = 0; e < NEVAL; e++) begin
      vectors++;
      if (chal_l[e] !== chal_exp(64'h5, e / NV) || chal_s[e] !== chal_l[e]) begin
        miscompares++;
        $display("FAIL ones_chal[%0d]: got %h/%h expected %h", e, chal_l[e], chal_s[e], chal_exp(64'h5, e / NV));
      end
    end
    vectors++;
    if (challenge !== chal_exp(64'h5, RW)) begin
      miscompares++; $display("FAIL ones_done_chal: got %h expected %h", challenge, chal_exp(64'h5, RW));
    end
    ref_data = resp_data; ref_unst = resp_unstable; ref_chal = challenge;
    accept();
    vectors++;
    if ({busy, resp_valid, resp_data} !== {2'b00, 4'hF}) begin
      miscompares++; $display("FAIL ones_after_accept: got %b expected 001111", {busy, resp_valid, resp_data});
    end
  endtask

  task automatic test_all_zeros();
    logic [63:0] sd = {$urandom, $urandom};
    collect(sd, '0, 1'b0);
    vectors++;
    if (data_after_start !== '0) begin
      miscompares++; $display("FAIL zeros_clear_on_start: got %h expected 0", data_after_start);
    end
    vectors++;
    if ({resp_data, resp_unstable} !== 8'h00) begin
      miscompares++; $display("FAIL zeros_result: got %h/%h expected 0/0", resp_data, resp_unstable);
    end
    vectors++;
    if (low_in_win !== NEVAL * (ST + 2) || pre_hi !== NEVAL) begin
      miscompares++;
      $display("FAIL zeros_arb_rst: got low=%0d prehi=%0d expected %0d/%0d", low_in_win, pre_hi, NEVAL * (ST + 2), NEVAL);
    end
    vectors++;
    if (lat !== LAT) begin miscompares++; $display("FAIL zeros_latency: got %0d expected %0d", lat, LAT); end
    accept();
  endtask

  task automatic test_mixed();
    logic [NEVAL-1:0] v = 12'b100_100_100_101;
    collect(64'h1234, v, 1'b0);
    vectors++;
    if ({resp_data, resp_unstable} !== {4'b0001, 4'b1111}) begin
      miscompares++; $display("FAIL mixed_result: got %b/%b expected 0001/1111", resp_data, resp_unstable);
    end
    accept();
  endtask

  task automatic test_seed_zero_busy();
    logic [NEVAL-1:0] v = NEVAL'($urandom);
    logic [RW-1:0]    d, u;
    model(v, d, u);
    collect(64'h0, v, 1'b1);
    vectors++;
    if (chal_l[0] !== 64'h1 || chal_l[NV] !== 64'hD800_0000_0000_0000) begin
      miscompares++; $display("FAIL seed0_first: got %h/%h expected 1/d800000000000000", chal_l[0], chal_l[NV]);
    end
    for (int e = 0; e < NEVAL; e++) begin
      vectors++;
      if (chal_l[e] !== chal_exp(64'h0, e / NV)) begin
        miscompares++; $display("FAIL seed0_chain[%0d]: got %h expected %h", e, chal_l[e], chal_exp(64'h0, e / NV));
      end
    end
    vectors++;
    if (lat !== LAT || nlaunch !== NEVAL || {resp_data, resp_unstable} !== {d, u}) begin
      miscompares++;
      $display("FAIL seed0_busy_start: got lat=%0d n=%0d %h/%h expected %0d %0d %h/%h", lat, nlaunch,
               resp_data, resp_unstable, LAT, NEVAL, d, u);
    end
    accept();
  endtask

  task automatic test_backpressure();
    logic [NEVAL-1:0] v = NEVAL'($urandom);
    logic [63:0]      sd = {$urandom, $urandom};
    logic [RW-1:0]    d, u;
    model(v, d, u);
    collect(sd, v, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({resp_valid, busy, resp_data, resp_unstable, challenge} !== {2'b11, d, u, chal_exp(sd, RW)}) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %b%b %h/%h %h expected 11 %h/%h %h", i, resp_valid, busy,
                 resp_data, resp_unstable, challenge, d, u, chal_exp(sd, RW));
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    vectors++;
    if ({resp_valid, busy, resp_data} !== {2'b00, d}) begin
      miscompares++; $display("FAIL release: got %b%b %h expected 00 %h", resp_valid, busy, resp_data, d);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit found = 1'b0;
    reset_dut();
    @(negedge clk); seed = 64'h5; start = 1'b1; arb_q = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (launch === 1'b1) n++;
      if (n == 2 * NV + 1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL midrst_wait: got %0d launches expected %0d", n, 2 * NV + 1); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({busy, arb_rst, launch, resp_valid, resp_data, resp_unstable, challenge} !== {4'b0100, 72'h0}) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %b%b%b%b %h/%h %h expected 0100 0/0 0", busy, arb_rst, launch,
               resp_valid, resp_data, resp_unstable, challenge);
    end
    @(negedge clk); rst = 1'b1;
    collect(64'h5, '1, 1'b0);
    vectors++;
    if (lat !== LAT || {resp_data, resp_unstable, challenge} !== {ref_data, ref_unst, ref_chal}) begin
      miscompares++;
      $display("FAIL midrst_restart: got %0d %h/%h %h expected %0d %h/%h %h", lat, resp_data,
               resp_unstable, challenge, LAT, ref_data, ref_unst, ref_chal);
    end
    accept();
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      logic [NEVAL-1:0] v = NEVAL'($urandom);
      logic [63:0]      sd = {$urandom, $urandom};
      logic [RW-1:0]    d, u;
      model(v, d, u);
      collect(sd, v, 1'b0);
      vectors++;
      if (lat !== LAT || {resp_data, resp_unstable} !== {d, u}) begin
        miscompares++;
        $display("FAIL random[%0d]: got %0d %h/%h expected %0d %h/%h (votes %b)", t, lat, resp_data,
                 resp_unstable, LAT, d, u, v);
      end
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_mixed();
    test_seed_zero_busy();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
